mem_bank_arbiter: RTL and testbench
===================================

MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- MEM_WORD_AW, 19, word-address width of the banked memory (2 MiB)
- STARVE_LIMIT, 4, consecutive lost arbitrations before fetch is forced (fixed-priority mode only)

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, synchronous, active-high reset
- if_req_i, in, 1, instruction-fetch read request
- if_addr_i, in, 32, fetch byte address
- if_ack_o, out, 1, fetch complete; if_rdata_o valid
- if_rdata_o, out, 32, fetch data
- dm_req_i, in, 1, data-bus request
- dm_we_i, in, 1, 1 = store, 0 = load
- dm_be_i, in, 4, store byte enables; bit n selects mem bank n
- dm_addr_i, in, 32, data byte address
- dm_wdata_i, in, 32, store data
- dm_ack_o, out, 1, data access complete
- dm_err_o, out, 1, with dm_ack_o: address out of range
- dm_rdata_o, out, 32, load data
- mem_en_o, out, 1, memory access strobe
- mem_we_o, out, 4, per-bank write enables (banks 0..3)
- mem_addr_o, out, MEM_WORD_AW, word address (byte address bits [MEM_WORD_AW+1:2])
- mem_wdata_o, out, 32, write data
- mem_rdata_i, in, 32, read data, valid one cycle after mem_en_o

Function
REQ-003 SHALL implement FSM states IDLE and BUSY; at most one access is outstanding.
REQ-004 In IDLE with at least one valid request, SHALL grant one requester, drive mem_en_o=1 and the winner's address/data combinationally in that cycle, record the owner, and go to BUSY.
REQ-005 In BUSY, SHALL assert the owner's ack for exactly one cycle, drive its rdata from mem_rdata_i, and return to IDLE; no grant is issued in BUSY. Throughput is 1 access per 2 cycles; latency is request-to-ack = 1 cycle.
REQ-006 A requester SHALL hold req and all payload stable until its ack. It may re-assert in the cycle after its ack.
REQ-007 mem_we_o SHALL equal dm_be_i when a store is granted, and 4'b0000 otherwise. Fetches and loads always read all 4 banks.
REQ-008 A data request with dm_addr_i[31:MEM_WORD_AW+2] nonzero SHALL be granted without mem_en_o. It is acked next cycle with dm_err_o=1 and dm_rdata_o=0. Fetch addresses are not range-checked: upper bits are ignored.
REQ-009 Outputs when not acking: if_rdata_o=0, dm_rdata_o=0, dm_err_o=0.
REQ-010 Simultaneous requests SHALL be resolved per REQ-015/REQ-016.

Reset
REQ-011 On rst=1 at a clock edge: FSM to IDLE, owner cleared, priority pointer to "data", starvation counter to 0.
REQ-012 During rst=1 and the cycle after, SHALL drive all outputs to 0 and ignore requests.
REQ-013 rst asserted while in BUSY SHALL abort the access with no ack issued. Requesters re-request after reset.

Configuration
REQ-014 The macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-015 With MEM_ARB_RR_EN defined: round-robin on a tie. The requester not served last wins; the pointer updates on every grant.
REQ-016 Without it: data wins a tie, and a saturating counter tracks consecutive fetch losses. When the counter equals STARVE_LIMIT, fetch wins the next tie. The counter clears on every fetch grant.

Verification
REQ-017 Lone fetch, if_addr_i=0x0000_0010, mem_rdata_i=0xDEAD_BEEF in the next cycle -> mem_en_o=1 and mem_addr_o=4 in cycle 0; if_ack_o=1 and if_rdata_o=0xDEAD_BEEF in cycle 1.
REQ-018 Store with dm_addr_i=0x001F_FE68, dm_be_i=4'b0011, dm_wdata_i=0x1234_5678 -> mem_we_o=4'b0011, mem_addr_o=0x7FF9A, mem_wdata_o=0x1234_5678; dm_ack_o=1 one cycle later.
REQ-019 Load with dm_addr_i=0x0020_0000 -> mem_en_o=0; next cycle dm_ack_o=1, dm_err_o=1, dm_rdata_o=0.
REQ-020 Both requesters held continuously for 12 cycles. With RR: grants alternate D,I,D,I,D,I. Without RR: grants are D,D,D,D,I,D (STARVE_LIMIT=4).
REQ-021 rst pulsed in the BUSY cycle of a load -> no dm_ack_o; all outputs 0 through the cycle after reset; the next request is serviced normally.
REQ-022 Fetch re-asserted in the cycle immediately after its ack -> mem_en_o=1 in that same cycle; no lost or duplicated ack.

Source files
------------

// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: two-port (fetch/data) arbiter onto a 4-bank 32-bit memory, one access per 2 cycles.
// Define MEM_ARB_RR_EN for round-robin ties; default is data priority with fetch starvation guard.
module mem_bank_arbiter #(
    parameter int MEM_WORD_AW  = 19,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [31:0]            if_addr_i,
    output logic                   if_ack_o,
    output logic [31:0]            if_rdata_o,
    input  logic                   dm_req_i,
    input  logic                   dm_we_i,
    input  logic [3:0]             dm_be_i,
    input  logic [31:0]            dm_addr_i,
    input  logic [31:0]            dm_wdata_i,
    output logic                   dm_ack_o,
    output logic                   dm_err_o,
    output logic [31:0]            dm_rdata_o,
    output logic                   mem_en_o,
    output logic [3:0]             mem_we_o,
    output logic [MEM_WORD_AW-1:0] mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {IDLE, BUSY} state_e;
    state_e        state_q, state_d;
    logic          owner_if_q, owner_if_d, err_q, err_d, prio_if_q, prio_if_d, rst_dly_q;
    logic [SW-1:0] starve_q, starve_d;
    logic          blk, go, ack, gnt_if, gnt_dm, dm_oor, starved;
    logic          unused_bits;
    assign unused_bits = ^{if_addr_i[31:MEM_WORD_AW+2], if_addr_i[1:0], dm_addr_i[1:0], prio_if_q};
    always_comb begin
        blk = rst | rst_dly_q;
        starved = (starve_q == SW'(STARVE_LIMIT));
`ifdef MEM_ARB_RR_EN
        gnt_if = if_req_i & (~dm_req_i | prio_if_q);
`else
        gnt_if = if_req_i & (~dm_req_i | starved);
`endif
        gnt_dm = dm_req_i & ~gnt_if;
        dm_oor = |dm_addr_i[31:MEM_WORD_AW+2];
        go = (state_q == IDLE) & ~blk & (if_req_i | dm_req_i);
        ack = (state_q == BUSY) & ~blk;
        mem_en_o = go & (gnt_if | ~dm_oor);
        mem_we_o = (go & gnt_dm & dm_we_i & ~dm_oor) ? dm_be_i : 4'b0000;
        mem_addr_o = ~go ? '0 : gnt_if ? if_addr_i[MEM_WORD_AW+1:2] : dm_addr_i[MEM_WORD_AW+1:2];
        mem_wdata_o = (go & gnt_dm) ? dm_wdata_i : '0;
        if_ack_o = ack & owner_if_q;
        dm_ack_o = ack & ~owner_if_q;
        dm_err_o = dm_ack_o & err_q;
        if_rdata_o = if_ack_o ? mem_rdata_i : '0;
        dm_rdata_o = (dm_ack_o & ~err_q) ? mem_rdata_i : '0;
        state_d = go ? BUSY : IDLE;
        owner_if_d = go ? gnt_if : owner_if_q;
        err_d = go ? (gnt_dm & dm_oor) : err_q;
        prio_if_d = go ? gnt_dm : prio_if_q;
        starve_d = (go & gnt_if) ? '0 :
                   (go & gnt_dm & if_req_i & ~starved) ? starve_q + SW'(1) : starve_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_if_q <= 1'b0;
            err_q      <= 1'b0;
            prio_if_q  <= 1'b0;
            starve_q   <= '0;
            rst_dly_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            err_q      <= err_d;
            prio_if_q  <= prio_if_d;
            starve_q   <= starve_d;
            rst_dly_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter: directed checks of grant, ack, range error, reset abort and tie resolution.
module tb_mem_bank_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
    logic [3:0]  dm_be_i = 4'b0000;
    logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
    logic        if_ack_o, dm_ack_o, dm_err_o, mem_en_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
    logic [3:0]  mem_we_o;
    logic [18:0] mem_addr_o;
    logic        any_out;
    int          n_chk = 0, n_fail = 0;
    logic [1:0]  ack_seq [6];
    logic [1:0]  exp_seq [6];

    mem_bank_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o), .dm_rdata_o(dm_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;
    assign any_out = |{if_ack_o, if_rdata_o, dm_ack_o, dm_err_o, dm_rdata_o,
                       mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif
        if_req_i = 1'b1; dm_req_i = 1'b1; dm_addr_i = 32'h40; mem_rdata_i = 32'h1111_2222;
        #2 chk("rst_outs_zero", 32'(any_out), 0);
        tick();
        tick();
        rst = 1'b0;
        #1 chk("post_rst_outs_zero", 32'(any_out), 0);
        if_req_i = 1'b0; dm_req_i = 1'b0;
        tick();

        if_req_i = 1'b1; dm_req_i = 1'b1; if_addr_i = 32'h80;
        for (int i = 0; i < 12; i++) begin
            #1 if (i % 2 == 1) ack_seq[i/2] = {if_ack_o, dm_ack_o};
            tick();
        end
        if_req_i = 1'b0; dm_req_i = 1'b0;
        for (int k = 0; k < 6; k++) chk($sformatf("tie_grant_%0d", k), 32'(ack_seq[k]), 32'(exp_seq[k]));
        tick();

        if_req_i = 1'b1; if_addr_i = 32'h10;
        #1 chk("fetch_en", 32'(mem_en_o), 1);
        chk("fetch_addr", 32'(mem_addr_o), 4);
        chk("fetch_no_early_ack", 32'(if_ack_o), 0);
        tick();
        mem_rdata_i = 32'hDEAD_BEEF;
        #1 chk("fetch_ack", 32'(if_ack_o), 1);
        chk("fetch_rdata", if_rdata_o, 32'hDEAD_BEEF);
        chk("busy_no_grant", 32'(mem_en_o), 0);
        chk("fetch_no_dm_ack", 32'(dm_ack_o), 0);
        tick();
        if_addr_i = 32'h20;
        #1 chk("refetch_en", 32'(mem_en_o), 1);
        chk("refetch_addr", 32'(mem_addr_o), 8);
        chk("refetch_no_ack", 32'(if_ack_o), 0);
        tick();
        #1 chk("refetch_ack", 32'(if_ack_o), 1);
        tick();
        if_req_i = 1'b0;
        #1 chk("no_dup_ack", 32'(if_ack_o), 0);
        chk("idle_rdata_zero", if_rdata_o, 0);
        tick();

        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'b0011;
        dm_addr_i = 32'h001F_FE68; dm_wdata_i = 32'h1234_5678;
        #1 chk("store_en", 32'(mem_en_o), 1);
        chk("store_we", 32'(mem_we_o), 32'h3);
        chk("store_addr", 32'(mem_addr_o), 32'h7FF9A);
        chk("store_wdata", mem_wdata_o, 32'h1234_5678);
        tick();
        #1 chk("store_ack", 32'(dm_ack_o), 1);
        chk("store_no_err", 32'(dm_err_o), 0);
        chk("busy_we_zero", 32'(mem_we_o), 0);
        tick();
        dm_we_i = 1'b0; dm_be_i = 4'b1111; dm_addr_i = 32'h100;
        #1 chk("load_en", 32'(mem_en_o), 1);
        chk("load_we_zero", 32'(mem_we_o), 0);
        chk("load_addr", 32'(mem_addr_o), 32'h40);
        tick();
        mem_rdata_i = 32'hCAFE_F00D;
        #1 chk("load_ack", 32'(dm_ack_o), 1);
        chk("load_rdata", dm_rdata_o, 32'hCAFE_F00D);
        tick();

        dm_addr_i = 32'h0020_0000;
        #1 chk("oor_no_en", 32'(mem_en_o), 0);
        tick();
        #1 chk("oor_ack", 32'(dm_ack_o), 1);
        chk("oor_err", 32'(dm_err_o), 1);
        chk("oor_rdata_zero", dm_rdata_o, 0);
        tick();
        dm_req_i = 1'b0;
        #1 chk("idle_err_zero", 32'(dm_err_o), 0);
        tick();

        dm_req_i = 1'b1; dm_addr_i = 32'h40;
        #1 chk("pre_abort_en", 32'(mem_en_o), 1);
        tick();
        rst = 1'b1;
        #1 chk("abort_no_ack", 32'(dm_ack_o), 0);
        chk("abort_outs_zero", 32'(any_out), 0);
        dm_req_i = 1'b0;
        tick();
        rst = 1'b0; dm_req_i = 1'b1;
        #1 chk("abort_dly_outs_zero", 32'(any_out), 0);
        tick();
        #1 chk("after_rst_en", 32'(mem_en_o), 1);
        chk("after_rst_addr", 32'(mem_addr_o), 32'h10);
        tick();
        mem_rdata_i = 32'h5A5A_0F0F;
        #1 chk("after_rst_ack", 32'(dm_ack_o), 1);
        chk("after_rst_rdata", dm_rdata_o, 32'h5A5A_0F0F);
        tick();
        dm_req_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
